uart_tx: RTL and testbench

UART transmitter that acts as the reader end of a `fifo` instance. It pops bytes from the FIFO read port (`rport_o`, `rdeq_i`, `empty_o`) and serialises each one onto `txd_o`, LSB first. It supports programmable baud divisor, optional parity, 1 or 2 stop bits and CTS flow control. It sits between the NORA TX FIFO and the UART pin.

---
 rtl/uart_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter draining a FIFO read port onto txd_o
// Frame: start, DATABITS data LSB first, optional parity, 1 or 2 stop bits.
module uart_tx #(
  parameter int DATABITS = 8,
  parameter int DIVW     = 16
) (
  input  logic                clk6x,
  input  logic                resetn,
  input  logic [DIVW-1:0]     baud_div_i,
  input  logic                parity_en_i,
  input  logic                parity_odd_i,
  input  logic                stop2_i,
  input  logic                cts_i,
  input  logic [DATABITS-1:0] fifo_data_i,
  input  logic                fifo_empty_i,
  output logic                fifo_deq_o,
  output logic                txd_o,
  output logic                busy_o
);

  localparam int CW = $clog2(DATABITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [DIVW-1:0]     baud_cnt_q, baud_cnt_d;
  logic [DIVW-1:0]     div_q, div_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATABITS-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic                par_en_q, par_en_d;
  logic                stop2_q, stop2_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                deq_q, deq_d;

  logic bit_end;
  logic last_stop;
  logic load;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    deq_d      = 1'b0;

    bit_end   = (baud_cnt_q == div_q);
    last_stop = (state_q == STOP) && bit_end &&
                (bit_cnt_q == {{(CW-1){1'b0}}, stop2_q});
    load      = ((state_q == IDLE) || last_stop) && !fifo_empty_i && cts_i;

    if (state_q != IDLE) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
    end

    // txd_d always carries the value of the bit that begins at this edge
    case (state_q)
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          txd_d     = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == CW'(DATABITS - 1)) begin
            bit_cnt_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            txd_d     = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d   = STOP;
          bit_cnt_d = '0;
          txd_d     = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            txd_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
      end
    endcase

    // A load overrides the end-of-frame return to IDLE for back-to-back frames
    if (load) begin
      shift_d    = fifo_data_i;
      div_d      = baud_div_i;
      par_d      = (^fifo_data_i) ^ parity_odd_i;
      par_en_d   = parity_en_i;
      stop2_d    = stop2_i;
      txd_d      = 1'b0;
      busy_d     = 1'b1;
      deq_d      = 1'b1;
      state_d    = START;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      deq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      deq_q      <= deq_d;
    end
  end

  assign txd_o      = txd_q;
  assign busy_o     = busy_q;
  assign fifo_deq_o = deq_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx
// Stimulus pushes bytes plus expected frames; a line monitor checks txd_o clock by clock.
module tb_uart_tx;

  logic        clk6x = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] baud_div_i = 16'd3;
  logic        parity_en_i = 1'b0;
  logic        parity_odd_i = 1'b0;
  logic        stop2_i = 1'b0;
  logic        cts_i = 1'b1;
  logic [7:0]  fifo_data_i;
  logic        fifo_empty_i;
  logic        fifo_deq_o;
  logic        txd_o;
  logic        busy_o;

  always #5 clk6x = ~clk6x;

  uart_tx #(.DATABITS(8), .DIVW(16)) dut (
    .clk6x        (clk6x),
    .resetn       (resetn),
    .baud_div_i   (baud_div_i),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .stop2_i      (stop2_i),
    .cts_i        (cts_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_deq_o   (fifo_deq_o),
    .txd_o        (txd_o),
    .busy_o       (busy_o)
  );

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] div;
    logic        par_en;
    logic        par_bit;
    logic        stop2;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  // Simple FIFO model: the initial block owns wr_ptr, the pop process owns rd_ptr
  logic [7:0] fifo_mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty_i = (wr_ptr == rd_ptr);
  assign fifo_data_i  = fifo_mem[rd_ptr[4:0]];

  int cyc = 0;
  always @(posedge clk6x) cyc <= cyc + 1;

  int deq_count = 0;
  int deq_cyc [0:63];
  always @(negedge clk6x) begin
    if (resetn && fifo_deq_o) begin
      deq_cyc[deq_count[5:0]] = cyc;
      deq_count = deq_count + 1;
      checks = checks + 1;
      if (wr_ptr == rd_ptr) begin
        failures = failures + 1;
        $display("FAIL deq_on_empty actual=deq required=no_deq");
      end else begin
        rd_ptr = rd_ptr + 1;
      end
    end
  end

  int busy_run = 0;
  int last_busy_len = 0;
  always @(negedge clk6x) begin
    if (!resetn) busy_run = 0;
    else if (busy_o) busy_run = busy_run + 1;
    else if (busy_run != 0) begin
      last_busy_len = busy_run;
      busy_run = 0;
    end
  end

  logic        mon_active = 1'b0;
  logic [11:0] mon_bits;
  logic [7:0]  mon_data;
  int          mon_idx, mon_len, mon_div, mon_err;
  exp_t        mon_e;

  always @(negedge clk6x) begin
    if (!resetn) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && txd_o == 1'b0) begin
        if (exp_q.size() == 0) begin
          checks = checks + 1;
          failures = failures + 1;
          $display("FAIL unexpected_start actual=start_bit required=idle");
        end else begin
          mon_e = exp_q.pop_front();
          mon_bits = '1;
          mon_bits[0] = 1'b0;
          for (int k = 0; k < 8; k++) mon_bits[k+1] = mon_e.data[k];
          mon_len = 10;
          if (mon_e.par_en) begin
            mon_bits[9] = mon_e.par_bit;
            mon_len = 11;
          end
          if (mon_e.stop2) mon_len = mon_len + 1;
          mon_div = int'(mon_e.div);
          mon_len = mon_len * (mon_div + 1);
          mon_data = mon_e.data;
          mon_idx = 0;
          mon_err = 0;
          mon_active = 1'b1;
        end
      end
      if (mon_active) begin
        if (txd_o !== mon_bits[mon_idx / (mon_div + 1)] || busy_o !== 1'b1)
          mon_err = mon_err + 1;
        mon_idx = mon_idx + 1;
        if (mon_idx == mon_len) begin
          mon_active = 1'b0;
          checks = checks + 1;
          if (mon_err != 0) begin
            failures = failures + 1;
            $display("FAIL frame_%02h actual=%0d_bad_clocks required=0", mon_data, mon_err);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic pbit);
    exp_t e;
    fifo_mem[wr_ptr[4:0]] = d;
    wr_ptr = wr_ptr + 1;
    e.data = d;
    e.div = baud_div_i;
    e.par_en = parity_en_i;
    e.par_bit = pbit;
    e.stop2 = stop2_i;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk6x);
      #1;
      if (!busy_o && !mon_active && exp_q.size() == 0 && fifo_empty_i) ok = 1'b1;
    end
    check({name, "_done"}, {31'd0, ok}, 32'd1);
  endtask

  int d0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk6x);
    #1;
    check("rst_txd", {31'd0, txd_o}, 32'd1);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_deq", {31'd0, fifo_deq_o}, 32'd0);
    resetn = 1'b1;

    // 1: empty FIFO keeps the line idle
    repeat (20) @(negedge clk6x);
    #1;
    check("empty_deq_count", deq_count, 0);
    check("empty_txd", {31'd0, txd_o}, 32'd1);
    check("empty_busy", {31'd0, busy_o}, 32'd0);

    // 2: 8N1, divisor 3, byte 0x12 -> 40 clocks
    baud_div_i = 16'd3;
    push(8'h12, 1'b0);
    wait_idle("t2", 200);
    check("t2_deq_count", deq_count, 1);
    check("t2_busy_len", last_busy_len, 40);

    // 3: divisor 0, four back-to-back frames
    baud_div_i = 16'd0;
    d0 = deq_count;
    push(8'h12, 1'b0);
    push(8'h34, 1'b0);
    push(8'h56, 1'b0);
    push(8'h78, 1'b0);
    wait_idle("t3", 200);
    check("t3_deq_count", deq_count - d0, 4);
    for (int i = 1; i < 4; i++)
      check("t3_deq_gap", deq_cyc[d0 + i] - deq_cyc[d0 + i - 1], 10);
    check("t3_busy_len", last_busy_len, 40);
    check("t3_fifo_empty", {31'd0, fifo_empty_i}, 32'd1);

    // 4: parity and two stop bits, divisor 1
    baud_div_i = 16'd1;
    parity_en_i = 1'b1;
    parity_odd_i = 1'b0;
    push(8'h12, 1'b0);
    wait_idle("t4_even", 200);
    check("t4_even_len", last_busy_len, 22);
    parity_odd_i = 1'b1;
    push(8'h12, 1'b1);
    wait_idle("t4_odd", 200);
    parity_odd_i = 1'b0;
    stop2_i = 1'b1;
    push(8'h34, 1'b1);
    wait_idle("t4_stop2", 200);
    check("t4_stop2_len", last_busy_len, 24);
    parity_en_i = 1'b0;
    stop2_i = 1'b0;

    // 5: CTS flow control
    @(negedge clk6x);
    cts_i = 1'b0;
    d0 = deq_count;
    push(8'hA5, 1'b0);
    push(8'h3C, 1'b0);
    repeat (20) @(negedge clk6x);
    #1;
    check("t5_hold_deq", deq_count - d0, 0);
    check("t5_hold_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk6x);
    cts_i = 1'b1;
    @(negedge clk6x);
    #1;
    check("t5_start1", {31'd0, busy_o}, 32'd1);
    repeat (5) @(negedge clk6x);
    cts_i = 1'b0;
    begin
      logic fell;
      fell = 1'b0;
      for (int i = 0; i < 100 && !fell; i++) begin
        @(negedge clk6x);
        #1;
        if (!busy_o) fell = 1'b1;
      end
      check("t5_frame1_done", {31'd0, fell}, 32'd1);
    end
    repeat (10) @(negedge clk6x);
    #1;
    check("t5_frame2_held", deq_count - d0, 1);
    check("t5_held_txd", {31'd0, txd_o}, 32'd1);
    cts_i = 1'b1;
    @(negedge clk6x);
    #1;
    check("t5_start2", {31'd0, busy_o}, 32'd1);
    wait_idle("t5", 200);
    check("t5_deq_count", deq_count - d0, 2);

    // 6: reset in the data bits of 0x9A, then a clean frame
    baud_div_i = 16'd3;
    push(8'h9A, 1'b0);
    begin
      logic up;
      up = 1'b0;
      for (int i = 0; i < 20 && !up; i++) begin
        @(negedge clk6x);
        if (busy_o) up = 1'b1;
      end
      check("t6_started", {31'd0, up}, 32'd1);
    end
    repeat (12) @(negedge clk6x);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_txd", {31'd0, txd_o}, 32'd1);
    check("t6_rst_busy", {31'd0, busy_o}, 32'd0);
    check("t6_rst_deq", {31'd0, fifo_deq_o}, 32'd0);
    push(8'hC3, 1'b0);
    repeat (3) @(negedge clk6x);
    resetn = 1'b1;
    wait_idle("t6", 200);
    check("t6_busy_len", last_busy_len, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
